cp0_exception_ctrl: RTL and testbench

//  Sequencer for the CoProcessor 0 register file. It arbitrates interrupt, SYSCALL, ERET and MTC0 requests

---
 rtl/cp0_exception_ctrl.sv | 154 +++++++++++++++
 tb/tb_cp0_exception_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_ctrl.sv
// CP0 exception sequencer: arbitrates IRQ/SYSCALL/ERET/MTC0 and issues
// ordered single-port CP0 accesses, ending each sequence with a PC redirect.
module cp0_exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_3000,
    parameter logic [4:0]  EXC_SYS    = 5'b01000,
    parameter logic [4:0]  EXC_INT    = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  irq,
    input  logic        ins_valid,
    input  logic [31:0] pc_cur,
    input  logic        syscall_req,
    input  logic        eret_req,
    input  logic        mtc0_req,
    input  logic [4:0]  mtc0_reg,
    input  logic [31:0] mtc0_data,
    output logic        syscall_ack,
    output logic        eret_ack,
    output logic        mtc0_ack,
    output logic        irq_taken,
    output logic        stall,
    output logic        cp0_wen,
    output logic [4:0]  cp0_addr,
    output logic [31:0] cp0_wdata,
    input  logic [31:0] cp0_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_STAT, E_RD, E_STAT, REDIR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic        exc_q, exc_d;
    logic        irq_pend;

    assign irq_pend = (|(irq & status_q[15:10])) & status_q[0]
                    & ~status_q[1] & ins_valid;

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        exc_d       = exc_q;
        syscall_ack = 1'b0;
        eret_ack    = 1'b0;
        mtc0_ack    = 1'b0;
        irq_taken   = 1'b0;
        stall       = 1'b0;
        cp0_wen     = 1'b0;
        cp0_addr    = 5'd0;
        cp0_wdata   = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        // Outputs are forced quiet while reset is held so an abort is immediate.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (irq_pend) begin
                        irq_taken = 1'b1;
                        stall     = 1'b1;
                        epc_d     = pc_cur;
                        cause_d   = {16'b0, irq, 3'b0, EXC_INT, 2'b0};
                        exc_d     = 1'b1;
                        state_d   = W_EPC;
                    end else if (syscall_req) begin
                        syscall_ack = 1'b1;
                        stall       = 1'b1;
                        epc_d       = pc_cur;
                        cause_d     = {16'b0, irq, 3'b0, EXC_SYS, 2'b0};
                        exc_d       = 1'b1;
                        state_d     = W_EPC;
                    end else if (eret_req) begin
                        eret_ack = 1'b1;
                        stall    = 1'b1;
                        exc_d    = 1'b0;
                        state_d  = E_RD;
                    end else if (mtc0_req) begin
                        mtc0_ack  = 1'b1;
                        cp0_wen   = 1'b1;
                        cp0_addr  = mtc0_reg;
                        cp0_wdata = mtc0_data;
                        if (mtc0_reg == 5'd12) status_d = mtc0_data;
                    end
                end
                W_EPC: begin
                    stall     = 1'b1;
                    cp0_wen   = 1'b1;
                    cp0_addr  = 5'd14;
                    cp0_wdata = epc_q;
                    state_d   = W_CAUSE;
                end
                W_CAUSE: begin
                    stall     = 1'b1;
                    cp0_wen   = 1'b1;
                    cp0_addr  = 5'd13;
                    cp0_wdata = cause_q;
                    state_d   = W_STAT;
                end
                W_STAT: begin
                    stall     = 1'b1;
                    cp0_wen   = 1'b1;
                    cp0_addr  = 5'd12;
                    cp0_wdata = status_q | 32'h2;
                    status_d  = status_q | 32'h2;
                    state_d   = REDIR;
                end
                E_RD: begin
                    stall    = 1'b1;
                    cp0_addr = 5'd14;
                    epc_d    = cp0_rdata;
                    state_d  = E_STAT;
                end
                E_STAT: begin
                    stall     = 1'b1;
                    cp0_wen   = 1'b1;
                    cp0_addr  = 5'd12;
                    cp0_wdata = status_q & ~32'h2;
                    status_d  = status_q & ~32'h2;
                    state_d   = REDIR;
                end
                REDIR: begin
                    redirect    = 1'b1;
                    redirect_pc = exc_q ? EXC_VECTOR : epc_q;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            status_q <= 32'd0;
            epc_q    <= 32'd0;
            cause_q  <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            exc_q    <= exc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed bench for cp0_exception_ctrl with a small CP0 register model.
// Inputs change on negedge; outputs are checked 1 time unit later.
module tb_cp0_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq;
    logic        ins_valid;
    logic [31:0] pc_cur;
    logic        syscall_req, eret_req, mtc0_req;
    logic [4:0]  mtc0_reg;
    logic [31:0] mtc0_data;
    logic        syscall_ack, eret_ack, mtc0_ack, irq_taken, stall;
    logic        cp0_wen;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata, cp0_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;

    int tests = 0;
    int fails = 0;

    logic [31:0] cp0 [32];
    logic        mem_clr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) cp0[i] <= 32'd0;
        end else if (cp0_wen) begin
            cp0[cp0_addr] <= cp0_wdata;
        end
    end

    assign cp0_rdata = cp0[cp0_addr];

    cp0_exception_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq), .ins_valid(ins_valid),
        .pc_cur(pc_cur), .syscall_req(syscall_req),
        .eret_req(eret_req), .mtc0_req(mtc0_req),
        .mtc0_reg(mtc0_reg), .mtc0_data(mtc0_data),
        .syscall_ack(syscall_ack), .eret_ack(eret_ack),
        .mtc0_ack(mtc0_ack), .irq_taken(irq_taken), .stall(stall),
        .cp0_wen(cp0_wen), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bit_chk(input string tag, input logic obs,
                           input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic exc_seq(input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] stat);
        @(negedge clk);
        syscall_req = 1'b0;
        irq = 6'd0;
        #1;
        bit_chk("epc_wen", cp0_wen, 1'b1);
        chk("epc_addr", {27'b0, cp0_addr}, 32'd14);
        chk("epc_data", cp0_wdata, epc);
        bit_chk("epc_stall", stall, 1'b1);
        bit_chk("epc_mack", mtc0_ack, 1'b0);
        @(negedge clk); #1;
        chk("cause_addr", {27'b0, cp0_addr}, 32'd13);
        chk("cause_data", cp0_wdata, cause);
        bit_chk("cause_mack", mtc0_ack, 1'b0);
        @(negedge clk); #1;
        chk("stat_addr", {27'b0, cp0_addr}, 32'd12);
        chk("stat_data", cp0_wdata, stat);
        bit_chk("stat_stall", stall, 1'b1);
        @(negedge clk); #1;
        bit_chk("redir", redirect, 1'b1);
        chk("redir_pc", redirect_pc, 32'h0000_3000);
        bit_chk("redir_stall", stall, 1'b0);
        bit_chk("redir_wen", cp0_wen, 1'b0);
        bit_chk("redir_mack", mtc0_ack, 1'b0);
    endtask

    task automatic mtc0_once(input logic [4:0] r, input logic [31:0] d);
        @(negedge clk);
        mtc0_req = 1'b1; mtc0_reg = r; mtc0_data = d;
        #1;
        bit_chk("mtc0_ack", mtc0_ack, 1'b1);
        bit_chk("mtc0_wen", cp0_wen, 1'b1);
        chk("mtc0_addr", {27'b0, cp0_addr}, {27'b0, r});
        chk("mtc0_data", cp0_wdata, d);
        bit_chk("mtc0_stall", stall, 1'b0);
        @(negedge clk);
        mtc0_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        irq = 6'd0; ins_valid = 1'b0; pc_cur = 32'd0;
        syscall_req = 1'b0; eret_req = 1'b0; mtc0_req = 1'b0;
        mtc0_reg = 5'd0; mtc0_data = 32'd0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        #1;
        bit_chk("rst_stall", stall, 1'b0);
        bit_chk("rst_wen", cp0_wen, 1'b0);
        bit_chk("rst_redir", redirect, 1'b0);
        chk("rst_pc", redirect_pc, 32'd0);

        // 1: reset aborts a sequence in W_CAUSE
        @(negedge clk);
        rst = 1'b0;
        syscall_req = 1'b1; pc_cur = 32'h3010;
        #1;
        bit_chk("t1_ack", syscall_ack, 1'b1);
        @(negedge clk);
        syscall_req = 1'b0;
        #1;
        chk("t1_epc_addr", {27'b0, cp0_addr}, 32'd14);
        @(negedge clk); #1;
        chk("t1_cause_addr", {27'b0, cp0_addr}, 32'd13);
        rst = 1'b1;
        #1;
        bit_chk("t1_rst_wen", cp0_wen, 1'b0);
        bit_chk("t1_rst_stall", stall, 1'b0);
        chk("t1_rst_addr", {27'b0, cp0_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        bit_chk("t1_idle_stall", stall, 1'b0);
        bit_chk("t1_idle_wen", cp0_wen, 1'b0);
        bit_chk("t1_idle_redir", redirect, 1'b0);
        @(negedge clk); #1;
        bit_chk("t1_no_stat", cp0_wen, 1'b0);
        chk("t1_cp0_12", cp0[12], 32'd0);
        chk("t1_cp0_13", cp0[13], 32'd0);

        // 2: SYSCALL from reset state
        syscall_req = 1'b1; pc_cur = 32'h3010;
        #1;
        bit_chk("t2_ack", syscall_ack, 1'b1);
        bit_chk("t2_stall", stall, 1'b1);
        bit_chk("t2_wen", cp0_wen, 1'b0);
        exc_seq(32'h3010, 32'h20, 32'h2);
        @(negedge clk); #1;
        bit_chk("t2_redir_done", redirect, 1'b0);
        chk("t2_cp0_14", cp0[14], 32'h3010);
        chk("t2_cp0_13", cp0[13], 32'h20);
        chk("t2_cp0_12", cp0[12], 32'h2);

        // 3: enable IRQ line 0, then take an interrupt
        mtc0_once(5'd12, 32'h0401);
        irq = 6'b000001; ins_valid = 1'b1; pc_cur = 32'h3020;
        #1;
        bit_chk("t3_taken", irq_taken, 1'b1);
        bit_chk("t3_sys_ack", syscall_ack, 1'b0);
        bit_chk("t3_stall", stall, 1'b1);
        exc_seq(32'h3020, 32'h400, 32'h403);
        @(negedge clk);

        // 4a: EXL=1 masks the IRQ; SYSCALL wins instead
        irq = 6'b000001; syscall_req = 1'b1; pc_cur = 32'h3030;
        #1;
        bit_chk("t4a_taken", irq_taken, 1'b0);
        bit_chk("t4a_ack", syscall_ack, 1'b1);
        exc_seq(32'h3030, 32'h420, 32'h403);
        @(negedge clk);

        // 5: ERET returns to EPC and clears EXL
        mtc0_once(5'd14, 32'h3010);
        eret_req = 1'b1;
        #1;
        bit_chk("t5_ack", eret_ack, 1'b1);
        bit_chk("t5_stall", stall, 1'b1);
        @(negedge clk);
        eret_req = 1'b0;
        #1;
        chk("t5_rd_addr", {27'b0, cp0_addr}, 32'd14);
        bit_chk("t5_rd_wen", cp0_wen, 1'b0);
        bit_chk("t5_rd_stall", stall, 1'b1);
        @(negedge clk); #1;
        bit_chk("t5_st_wen", cp0_wen, 1'b1);
        chk("t5_st_addr", {27'b0, cp0_addr}, 32'd12);
        chk("t5_st_data", cp0_wdata, 32'h401);
        @(negedge clk); #1;
        bit_chk("t5_redir", redirect, 1'b1);
        chk("t5_redir_pc", redirect_pc, 32'h3010);
        bit_chk("t5_redir_stall", stall, 1'b0);
        @(negedge clk);

        // 4b: IM bit clear masks the IRQ; SYSCALL wins instead
        mtc0_once(5'd12, 32'h0001);
        irq = 6'b000001; ins_valid = 1'b1;
        syscall_req = 1'b1; pc_cur = 32'h3050;
        #1;
        bit_chk("t4b_taken", irq_taken, 1'b0);
        bit_chk("t4b_ack", syscall_ack, 1'b1);
        exc_seq(32'h3050, 32'h420, 32'h3);
        @(negedge clk);

        // 6: SYSCALL beats a simultaneous MTC0, which follows after REDIR
        syscall_req = 1'b1; pc_cur = 32'h3040;
        mtc0_req = 1'b1; mtc0_reg = 5'd9; mtc0_data = 32'hABCD;
        #1;
        bit_chk("t6_sys_ack", syscall_ack, 1'b1);
        bit_chk("t6_mtc0_ack", mtc0_ack, 1'b0);
        bit_chk("t6_wen", cp0_wen, 1'b0);
        exc_seq(32'h3040, 32'h20, 32'h3);
        @(negedge clk); #1;
        bit_chk("t6_mtc0_late", mtc0_ack, 1'b1);
        chk("t6_mtc0_addr", {27'b0, cp0_addr}, 32'd9);
        chk("t6_mtc0_data", cp0_wdata, 32'hABCD);
        bit_chk("t6_stall", stall, 1'b0);
        @(negedge clk);
        mtc0_req = 1'b0;
        #1;
        chk("t6_cp0_9", cp0[9], 32'hABCD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
